// File: rtl/load_store_unit_pkg.sv
// Shared load/store definitions: memory op encoding, LSU FSM states and op helpers.
package load_store_unit_pkg;

  typedef enum logic [1:0] {
    LW  = 2'd0,
    LBU = 2'd1,
    SW  = 2'd2,
    SB  = 2'd3
  } lsu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } lsu_state_e;

  function automatic logic is_store(input lsu_op_e op);
    return (op == SW) || (op == SB);
  endfunction

  function automatic logic is_word(input lsu_op_e op);
    return (op == LW) || (op == SW);
  endfunction

endpackage

// File: rtl/lsu_byte_lane.sv
// Byte-lane steering for the LSU: store byte enables / lane replication and LBU
// extraction with zero extension. Purely combinational.
module lsu_byte_lane
  import load_store_unit_pkg::*;
(
  input  lsu_op_e     op,
  input  logic [1:0]  byte_sel,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata_lane,
  output logic [31:0] load_data
);

  logic [7:0] rbyte;

  assign rbyte = rdata[{byte_sel, 3'b000} +: 8];

  always_comb begin
    be         = 4'hF;
    wdata_lane = wdata;
    load_data  = '0;
    case (op)
      LW:  load_data = rdata;
      LBU: begin
        be        = 4'b0001 << byte_sel;
        load_data = {24'd0, rbyte};
      end
      SW:  ;
      SB:  begin
        // Byte stores drive the byte on every lane; be selects the target.
        be         = 4'b0001 << byte_sel;
        wdata_lane = {4{wdata[7:0]}};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit (IDLE -> REQ -> WAIT -> RESP).
// Define LSU_MISALIGN_TRAP_EN to trap misaligned LW/SW without a memory access.
module load_store_unit
  import load_store_unit_pkg::*;
(
  input  logic        clk,
  input  logic        n_reset,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  lsu_op_e     req_op_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  output logic        resp_valid_o,
  output logic [31:0] resp_data_o,
  output logic        stall_o,
  output logic        mem_valid_o,
  input  logic        mem_ready_i,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  output logic [3:0]  mem_be_o,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i,
  output logic        err_o
);

  lsu_state_e  state, state_nxt;
  lsu_op_e     op_p0;
  logic [31:0] addr_p0, wdata_p0, rdata_p0;
  logic        accept, misalign, trap_p0;
  logic [3:0]  lane_be;
  logic [31:0] lane_wdata, lane_load;

  assign accept = req_valid_i && (state == IDLE);

`ifdef LSU_MISALIGN_TRAP_EN
  assign misalign = is_word(req_op_i) && (req_addr_i[1:0] != 2'b00);

  always_ff @(posedge clk) begin
    if (accept) trap_p0 <= misalign;
  end
`else
  assign misalign = 1'b0;
  assign trap_p0  = 1'b0;
`endif

  // Request capture stage; data registers need no reset since outputs are state-gated
  always_ff @(posedge clk) begin
    if (accept) begin
      op_p0    <= req_op_i;
      addr_p0  <= req_addr_i;
      wdata_p0 <= req_wdata_i;
    end
    if ((state == WAIT) && mem_rvalid_i) rdata_p0 <= mem_rdata_i;
  end

  always_ff @(posedge clk) begin
    if (!n_reset) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    req_ready_o  = 1'b0;
    stall_o      = 1'b0;
    mem_valid_o  = 1'b0;
    resp_valid_o = 1'b0;
    case (state)
      IDLE: begin
        req_ready_o = 1'b1;
        stall_o     = req_valid_i;
        if (req_valid_i) state_nxt = misalign ? RESP : REQ;
      end
      REQ: begin
        stall_o     = 1'b1;
        mem_valid_o = 1'b1;
        if (mem_ready_i) state_nxt = is_store(op_p0) ? RESP : WAIT;
      end
      WAIT: begin
        stall_o = 1'b1;
        if (mem_rvalid_i) state_nxt = RESP;
      end
      RESP: begin
        resp_valid_o = 1'b1;
        state_nxt    = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  lsu_byte_lane u_byte_lane (
    .op         (op_p0),
    .byte_sel   (addr_p0[1:0]),
    .wdata      (wdata_p0),
    .rdata      (rdata_p0),
    .be         (lane_be),
    .wdata_lane (lane_wdata),
    .load_data  (lane_load)
  );

  // Memory and response outputs are forced to zero outside their owning state
  assign mem_addr_o  = mem_valid_o ? {addr_p0[31:2], 2'b00} : 32'd0;
  assign mem_we_o    = mem_valid_o && is_store(op_p0);
  assign mem_be_o    = mem_valid_o ? lane_be : 4'd0;
  assign mem_wdata_o = mem_valid_o ? lane_wdata : 32'd0;
  assign resp_data_o = (resp_valid_o && !trap_p0) ? lane_load : 32'd0;
  assign err_o       = resp_valid_o && trap_p0;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: directed ops push expected responses, a monitor checks them.
module tb_load_store_unit;
  import load_store_unit_pkg::*;

  logic        clk = 1'b0;
  logic        n_reset;
  logic        req_valid;
  logic        req_ready_o;
  lsu_op_e     req_op;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid_o;
  logic [31:0] resp_data_o;
  logic        stall_o;
  logic        mem_valid_o;
  logic        mem_ready;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic [3:0]  mem_be_o;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        err_o;

  load_store_unit dut (
    .clk          (clk),
    .n_reset      (n_reset),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready_o),
    .req_op_i     (req_op),
    .req_addr_i   (req_addr),
    .req_wdata_i  (req_wdata),
    .resp_valid_o (resp_valid_o),
    .resp_data_o  (resp_data_o),
    .stall_o      (stall_o),
    .mem_valid_o  (mem_valid_o),
    .mem_ready_i  (mem_ready),
    .mem_we_o     (mem_we_o),
    .mem_addr_o   (mem_addr_o),
    .mem_wdata_o  (mem_wdata_o),
    .mem_be_o     (mem_be_o),
    .mem_rvalid_i (mem_rvalid),
    .mem_rdata_i  (mem_rdata),
    .err_o        (err_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] data;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  int total = 0;
  int bad = 0;
  int resp_cnt = 0;
  int last_resp_cyc = 0;
  int acc_cyc = 0;
  int resp_base = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // Monitor: every response pulse pops one expectation
  always @(negedge clk) begin : monitor
    exp_t e;
    if (resp_valid_o === 1'b1) begin
      resp_cnt++;
      last_resp_cyc = cyc;
      if (exp_q.size() == 0) begin
        chk1("unexpected_resp", resp_valid_o, 1'b0);
      end else begin
        e = exp_q.pop_front();
        chk("resp_data", resp_data_o, e.data);
        chk1("resp_err", err_o, e.err);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input lsu_op_e op, input logic [31:0] addr, input logic [31:0] wdata);
    tick();
    req_valid = 1'b1;
    req_op    = op;
    req_addr  = addr;
    req_wdata = wdata;
    acc_cyc   = cyc;
    resp_base = resp_cnt;
    @(negedge clk);
    chk1("accept_ready", req_ready_o, 1'b1);
    chk1("accept_stall", stall_o, 1'b1);
    tick();
    req_valid = 1'b0;
  endtask

  task automatic wait_resp(input string name, input int lat);
    int n = 0;
    while ((resp_cnt == resp_base) && (n < 30)) begin
      @(posedge clk);
      n++;
    end
    chk({name, "_resp_count"}, resp_cnt - resp_base, 32'd1);
    chk({name, "_latency"}, last_resp_cyc - acc_cyc, lat);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    n_reset    = 1'b0;
    req_valid  = 1'b0;
    req_op     = LW;
    req_addr   = '0;
    req_wdata  = '0;
    mem_ready  = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata  = '0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk1("rst_ready", req_ready_o, 1'b1);
    chk1("rst_stall", stall_o, 1'b0);
    chk1("rst_mem_valid", mem_valid_o, 1'b0);
    chk1("rst_resp_valid", resp_valid_o, 1'b0);
    chk1("rst_err", err_o, 1'b0);
    chk("rst_mem_addr", mem_addr_o, 32'h0);
    tick();
    req_valid = 1'b1;
    @(negedge clk);
    chk1("rst_stall_on_valid", stall_o, 1'b1);
    tick();
    req_valid = 1'b0;
    n_reset   = 1'b1;
    @(negedge clk);
    chk1("rst_held_idle", mem_valid_o, 1'b0);

    // SW, memory ready immediately
    mem_ready = 1'b1;
    exp_q.push_back('{32'h0, 1'b0});
    issue(SW, 32'h100, 32'hDEADBEEF);
    @(negedge clk);
    chk1("sw_mem_valid", mem_valid_o, 1'b1);
    chk1("sw_we", mem_we_o, 1'b1);
    chk("sw_addr", mem_addr_o, 32'h100);
    chk("sw_be", 32'(mem_be_o), 32'hF);
    chk("sw_wdata", mem_wdata_o, 32'hDEADBEEF);
    wait_resp("sw", 2);

    // SB to byte 3
    exp_q.push_back('{32'h0, 1'b0});
    issue(SB, 32'h203, 32'h000000A5);
    @(negedge clk);
    chk1("sb_we", mem_we_o, 1'b1);
    chk("sb_addr", mem_addr_o, 32'h200);
    chk("sb_be", 32'(mem_be_o), 32'h8);
    chk("sb_wdata", mem_wdata_o, 32'hA5A5A5A5);
    wait_resp("sb", 2);

    // LBU with mem_ready held low for 3 cycles
    mem_ready = 1'b0;
    exp_q.push_back('{32'h000000C2, 1'b0});
    issue(LBU, 32'h302, 32'h0);
    for (int i = 0; i < 4; i++) begin
      if (i > 0) tick();
      mem_ready = (i == 3);
      @(negedge clk);
      chk1("lbu_mem_valid", mem_valid_o, 1'b1);
      chk("lbu_addr", mem_addr_o, 32'h300);
      chk1("lbu_we", mem_we_o, 1'b0);
    end
    tick();
    mem_ready  = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h11C23344;
    @(negedge clk);
    chk1("lbu_wait_mem_valid", mem_valid_o, 1'b0);
    chk1("lbu_wait_stall", stall_o, 1'b1);
    tick();
    mem_rvalid = 1'b0;
    wait_resp("lbu", 6);

    // LW with rvalid 5 cycles after accept and a competing request during WAIT
    mem_ready = 1'b1;
    exp_q.push_back('{32'hCAFEF00D, 1'b0});
    issue(LW, 32'h40, 32'h0);
    for (int i = 1; i <= 5; i++) begin
      if (i > 1) tick();
      if (i == 2) begin
        mem_ready = 1'b0;
        req_valid = 1'b1;
        req_op    = SW;
        req_addr  = 32'h80;
        req_wdata = 32'h1;
      end
      if (i == 5) begin
        req_valid  = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hCAFEF00D;
      end
      @(negedge clk);
      chk1("lw_stall", stall_o, 1'b1);
      chk1("lw_not_ready", req_ready_o, 1'b0);
      if (i > 1) chk1("lw_no_reissue", mem_valid_o, 1'b0);
    end
    tick();
    mem_rvalid = 1'b0;
    wait_resp("lw", 6);
    tick();
    @(negedge clk);
    chk1("lw_stray_not_accepted", mem_valid_o, 1'b0);

    // Reset while waiting for read data; late rvalid must be dropped
    mem_ready = 1'b1;
    issue(LW, 32'h500, 32'h0);
    tick();
    n_reset = 1'b0;
    @(negedge clk);
    chk1("wrst_stall_in_wait", stall_o, 1'b1);
    tick();
    n_reset    = 1'b1;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h12345678;
    @(negedge clk);
    chk1("wrst_ready", req_ready_o, 1'b1);
    chk1("wrst_stall", stall_o, 1'b0);
    chk1("wrst_mem_valid", mem_valid_o, 1'b0);
    chk1("wrst_resp_valid", resp_valid_o, 1'b0);
    chk1("wrst_we", mem_we_o, 1'b0);
    chk("wrst_addr", mem_addr_o, 32'h0);
    chk("wrst_be", 32'(mem_be_o), 32'h0);
    chk("wrst_wdata", mem_wdata_o, 32'h0);
    chk("wrst_resp_data", resp_data_o, 32'h0);
    tick();
    mem_rvalid = 1'b0;
    repeat (3) tick();
    chk("wrst_no_resp", resp_cnt - resp_base, 32'd0);

    // Misaligned LW
`ifdef LSU_MISALIGN_TRAP_EN
    mem_ready = 1'b1;
    exp_q.push_back('{32'h0, 1'b1});
    issue(LW, 32'h41, 32'h0);
    @(negedge clk);
    chk1("mis_no_mem_valid", mem_valid_o, 1'b0);
    wait_resp("mis", 1);
`else
    mem_ready = 1'b1;
    exp_q.push_back('{32'h89ABCDEF, 1'b0});
    issue(LW, 32'h41, 32'h0);
    @(negedge clk);
    chk1("unal_mem_valid", mem_valid_o, 1'b1);
    chk("unal_addr", mem_addr_o, 32'h40);
    tick();
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h89ABCDEF;
    tick();
    mem_rvalid = 1'b0;
    wait_resp("unal", 3);
`endif

    repeat (3) tick();
    chk("scoreboard_drained", exp_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
